// File: rtl/led_pkg.sv
// led_pkg: shared address map and seven-segment decode table for the LED/tube peripheral
package led_pkg;
  localparam logic [2:0] LED_LO  = 3'b000;
  localparam logic [2:0] LED_HI  = 3'b010;
  localparam logic [2:0] TUBE_LO = 3'b100;
  localparam logic [2:0] TUBE_HI = 3'b110;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
endpackage

// File: rtl/led_tube_hex7seg.sv
// hex7seg: combinational nibble to active-low segment pattern, dp off
module hex7seg
  import led_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/led_tube.sv
// led_tube: CPU-written LED register plus 8-digit multiplexed seven-segment tube driver
module led_tube
  import led_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        ledclk,
  input  logic        ledrstn,
  input  logic        ledcs,
  input  logic        ledwrite,
  input  logic [2:0]  ledaddr,
  input  logic [15:0] ledwdata,
  output logic [23:0] led_o,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_o
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt;
  logic [2:0]    digit;
  logic [31:0]   tube;
  logic [7:0]    seg_d;
  logic          wr;
  logic          wrap;
  assign wr   = ledcs && ledwrite;
  assign wrap = cnt == CW'(SCAN_DIV - 1);
  hex7seg u_dec (
    .nib (tube[{digit, 2'b00} +: 4]),
    .seg (seg_d)
  );
  always_ff @(negedge ledclk or negedge ledrstn) begin
    if (!ledrstn) begin
      led_o  <= '0;
      tube   <= '0;
      cnt    <= '0;
      digit  <= '0;
      seg_en <= 8'hFE;
      seg_o  <= SEG_TABLE[0];
    end else begin
      cnt    <= wrap ? '0 : cnt + 1'b1;
      digit  <= wrap ? digit + 3'd1 : digit;
      seg_en <= ~(8'b1 << digit);
      seg_o  <= seg_d;
      if (wr && ledaddr == LED_LO)  led_o[15:0]  <= ledwdata;
      if (wr && ledaddr == LED_HI)  led_o[23:16] <= ledwdata[7:0];
      if (wr && ledaddr == TUBE_LO) tube[15:0]   <= ledwdata;
      if (wr && ledaddr == TUBE_HI) tube[31:16]  <= ledwdata;
    end
  end
endmodule

// File: tb/tb_led_tube.sv
// tb_led_tube: directed self-checking bench for led_tube with SCAN_DIV=4
module tb_led_tube;
  logic        ledclk = 1'b0;
  logic        ledrstn = 1'b0;
  logic        ledcs = 1'b0;
  logic        ledwrite = 1'b0;
  logic [2:0]  ledaddr = 3'b000;
  logic [15:0] ledwdata = 16'h0000;
  logic [23:0] led_o;
  logic [7:0]  seg_en;
  logic [7:0]  seg_o;
  int tests = 0;
  int fails = 0;

  led_tube #(.SCAN_DIV(4)) dut (
    .ledclk   (ledclk),
    .ledrstn  (ledrstn),
    .ledcs    (ledcs),
    .ledwrite (ledwrite),
    .ledaddr  (ledaddr),
    .ledwdata (ledwdata),
    .led_o    (led_o),
    .seg_en   (seg_en),
    .seg_o    (seg_o)
  );

  always #5 ledclk = ~ledclk;

  task automatic step();
    @(negedge ledclk);
    #1;
  endtask

  task automatic wr(input logic cs, input logic we, input logic [2:0] a, input logic [15:0] d);
    ledcs = cs;
    ledwrite = we;
    ledaddr = a;
    ledwdata = d;
    step();
    ledcs = 1'b0;
    ledwrite = 1'b0;
  endtask

  // leaves the bench 1 time unit after a falling edge with reset just released
  task automatic do_reset();
    step();
    ledrstn = 1'b0;
    step();
    step();
    ledrstn = 1'b1;
  endtask

  task automatic test_reset();
    step();
    ledrstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (led_o !== 24'h0 || seg_en !== 8'hFE || seg_o !== 8'hC0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got led=%h en=%h seg=%h, want 000000 FE C0", i, led_o, seg_en, seg_o);
      end
      step();
    end
    ledrstn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      tests++;
      if (led_o !== 24'h0 || seg_en !== 8'hFE || seg_o !== 8'hC0) begin
        fails++;
        $display("FAIL reset_release[%0d]: got led=%h en=%h seg=%h, want 000000 FE C0", k, led_o, seg_en, seg_o);
      end
    end
  endtask

  task automatic test_led_writes();
    do_reset();
    wr(1, 1, 3'b000, 16'hA5C3);
    tests++;
    if (led_o !== 24'h00A5C3) begin
      fails++;
      $display("FAIL led_lo: got %h want 00a5c3", led_o);
    end
    wr(1, 1, 3'b010, 16'hFF3C);
    tests++;
    if (led_o !== 24'h3CA5C3) begin
      fails++;
      $display("FAIL led_hi: got %h want 3ca5c3", led_o);
    end
    wr(1, 1, 3'b001, 16'h1111);
    wr(0, 1, 3'b000, 16'h2222);
    wr(1, 0, 3'b000, 16'h3333);
    wr(1, 1, 3'b011, 16'h4444);
    tests++;
    if (led_o !== 24'h3CA5C3) begin
      fails++;
      $display("FAIL led_ignored: got %h want 3ca5c3", led_o);
    end
  endtask

  task automatic test_scan();
    logic [7:0] en_tab [8];
    logic [7:0] seg_tab [8];
    en_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    seg_tab = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    do_reset();
    wr(1, 1, 3'b100, 16'h5678);
    wr(1, 1, 3'b110, 16'h1234);
    for (int k = 3; k <= 40; k++) begin
      int d;
      step();
      d = ((k - 1) / 4) % 8;
      tests++;
      if (seg_en !== en_tab[d] || seg_o !== seg_tab[d]) begin
        fails++;
        $display("FAIL scan[k=%0d]: got en=%h seg=%h, want en=%h seg=%h", k, seg_en, seg_o, en_tab[d], seg_tab[d]);
      end
    end
  endtask

  task automatic test_live_update();
    do_reset();
    wr(1, 1, 3'b100, 16'h000F);
    tests++;
    if (seg_en !== 8'hFE || seg_o !== 8'hC0) begin
      fails++;
      $display("FAIL live_write_edge: got en=%h seg=%h, want FE C0", seg_en, seg_o);
    end
    step();
    tests++;
    if (seg_en !== 8'hFE || seg_o !== 8'h8E) begin
      fails++;
      $display("FAIL live_next: got en=%h seg=%h, want FE 8E", seg_en, seg_o);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    step();
    step();
    step();
    wr(1, 1, 3'b100, 16'h00A0);
    tests++;
    if (seg_en !== 8'hFE || seg_o !== 8'hC0) begin
      fails++;
      $display("FAIL bound_wrap_edge: got en=%h seg=%h, want FE C0", seg_en, seg_o);
    end
    step();
    tests++;
    if (seg_en !== 8'hFD || seg_o !== 8'h88) begin
      fails++;
      $display("FAIL bound_new_digit: got en=%h seg=%h, want FD 88", seg_en, seg_o);
    end
    step();
    step();
    step();
    tests++;
    if (seg_en !== 8'hFD || seg_o !== 8'h88) begin
      fails++;
      $display("FAIL bound_dwell: got en=%h seg=%h, want FD 88", seg_en, seg_o);
    end
    step();
    tests++;
    if (seg_en !== 8'hFB || seg_o !== 8'hC0) begin
      fails++;
      $display("FAIL bound_next_digit: got en=%h seg=%h, want FB C0", seg_en, seg_o);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    wr(1, 1, 3'b000, 16'h1234);
    wr(1, 1, 3'b100, 16'h4321);
    for (int k = 3; k <= 22; k++) step();
    tests++;
    if (seg_en !== 8'hDF) begin
      fails++;
      $display("FAIL mid_pre: got en=%h want DF", seg_en);
    end
    ledrstn = 1'b0;
    #1;
    tests++;
    if (seg_en !== 8'hFE || seg_o !== 8'hC0 || led_o !== 24'h0) begin
      fails++;
      $display("FAIL mid_async: got led=%h en=%h seg=%h, want 000000 FE C0", led_o, seg_en, seg_o);
    end
    step();
    ledrstn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      tests++;
      if (seg_en !== (k <= 4 ? 8'hFE : 8'hFD) || seg_o !== 8'hC0) begin
        fails++;
        $display("FAIL mid_resume[k=%0d]: got en=%h seg=%h, want %h C0", k, seg_en, seg_o, k <= 4 ? 8'hFE : 8'hFD);
      end
    end
  endtask

  initial begin
    test_reset();
    test_led_writes();
    test_scan();
    test_live_update();
    test_boundary();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
